// File: rtl/pio_in_edge_irq.sv
// Input PIO Avalon-MM slave: input synchroniser, optional per-bit debounce,
// edge capture with write-1-to-clear, per-bit interrupt mask and level IRQ.
module pio_in_edge_irq #(
    parameter int WIDTH           = 4,
    parameter int SYNC_STAGES     = 2,
    parameter int DEBOUNCE_CYCLES = 0,
    parameter int EDGE_TYPE       = 0
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic [1:0]       address,
    input  logic             chipselect,
    input  logic             write_n,
    input  logic [31:0]      writedata,
    input  logic [WIDTH-1:0] in_port,
    output logic [31:0]      readdata,
    output logic             irq
);

    logic [SYNC_STAGES-1:0][WIDTH-1:0] sync_q;
    logic [WIDTH-1:0] sync_s;
    logic [WIDTH-1:0] filt;
    logic [WIDTH-1:0] filt_dly_q;
    logic [WIDTH-1:0] edge_ev;
    logic [WIDTH-1:0] mask_q, mask_d;
    logic [WIDTH-1:0] cap_q, cap_d;
    logic [WIDTH-1:0] clr;
    logic [31:0]      rdata_q, rdata_d;
    logic             irq_q, irq_d;
    logic             wr_en;
    logic             unused_wdata;

    assign unused_wdata = ^writedata;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sync_q <= '0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], in_port};
        end
    end

    assign sync_s = sync_q[SYNC_STAGES-1];

    generate
        if (DEBOUNCE_CYCLES == 0) begin : g_bypass
            assign filt = sync_s;
        end else begin : g_filter
            localparam int CW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
            localparam logic [CW-1:0] LAST = CW'(DEBOUNCE_CYCLES - 1);

            logic [CW-1:0]    cnt_q [WIDTH];
            logic [WIDTH-1:0] filt_q;

            // The filtered bit only follows the synchronised bit after it has
            // disagreed for DEBOUNCE_CYCLES consecutive clocks.
            always_ff @(posedge clk or negedge reset_n) begin
                if (!reset_n) begin
                    filt_q <= '0;
                    for (int unsigned i = 0; i < WIDTH; i++) begin
                        cnt_q[i] <= '0;
                    end
                end else begin
                    for (int unsigned i = 0; i < WIDTH; i++) begin
                        if (sync_s[i] == filt_q[i]) begin
                            cnt_q[i] <= '0;
                        end else if (cnt_q[i] == LAST) begin
                            filt_q[i] <= sync_s[i];
                            cnt_q[i]  <= '0;
                        end else begin
                            cnt_q[i] <= cnt_q[i] + 1'b1;
                        end
                    end
                end
            end

            assign filt = filt_q;
        end
    endgenerate

    always_comb begin
        if (EDGE_TYPE == 0) begin
            edge_ev = filt & ~filt_dly_q;
        end else if (EDGE_TYPE == 1) begin
            edge_ev = ~filt & filt_dly_q;
        end else begin
            edge_ev = filt ^ filt_dly_q;
        end
    end

    assign wr_en = chipselect & ~write_n;

    always_comb begin
        mask_d = mask_q;
        clr    = '0;
        if (wr_en && address == 2'd1) begin
            mask_d = writedata[WIDTH-1:0];
        end
        if (wr_en && address == 2'd2) begin
            clr = writedata[WIDTH-1:0];
        end
        // A new edge wins over a simultaneous clear of the same bit.
        cap_d = edge_ev | (cap_q & ~clr);
    end

    always_comb begin
        rdata_d = '0;
        case (address)
            2'd0:    rdata_d[WIDTH-1:0] = filt;
            2'd1:    rdata_d[WIDTH-1:0] = mask_q;
            2'd2:    rdata_d[WIDTH-1:0] = cap_q;
            default: rdata_d = '0;
        endcase
    end

    assign irq_d = |(cap_q & mask_q);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            filt_dly_q <= '0;
            mask_q     <= '0;
            cap_q      <= '0;
            rdata_q    <= '0;
            irq_q      <= 1'b0;
        end else begin
            filt_dly_q <= filt;
            mask_q     <= mask_d;
            cap_q      <= cap_d;
            rdata_q    <= rdata_d;
            irq_q      <= irq_d;
        end
    end

    assign readdata = rdata_q;
    assign irq      = irq_q;

endmodule

// File: tb/tb_pio_in_edge_irq.sv
// Bench for pio_in_edge_irq: three configurations on a shared bus, checked
// every cycle against a behavioural model plus directed literal expectations.
module tb_pio_in_edge_irq;

    logic        clk        = 1'b0;
    logic        reset_n    = 1'b0;
    logic [1:0]  address    = 2'd0;
    logic        chipselect = 1'b0;
    logic        write_n    = 1'b1;
    logic [31:0] writedata  = '0;
    logic [3:0]  in0        = '0;
    logic [3:0]  in1        = '0;
    logic [31:0] in2        = '0;
    logic [31:0] rd0, rd1, rd2;
    logic        irq0, irq1, irq2;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    // u0: basic rising edge; u1: debounced; u2: full width, any edge.
    pio_in_edge_irq #(.WIDTH(4), .SYNC_STAGES(2), .DEBOUNCE_CYCLES(0), .EDGE_TYPE(0)) u0 (
        .clk(clk), .reset_n(reset_n), .address(address), .chipselect(chipselect),
        .write_n(write_n), .writedata(writedata), .in_port(in0),
        .readdata(rd0), .irq(irq0));

    pio_in_edge_irq #(.WIDTH(4), .SYNC_STAGES(2), .DEBOUNCE_CYCLES(4), .EDGE_TYPE(0)) u1 (
        .clk(clk), .reset_n(reset_n), .address(address), .chipselect(chipselect),
        .write_n(write_n), .writedata(writedata), .in_port(in1),
        .readdata(rd1), .irq(irq1));

    pio_in_edge_irq #(.WIDTH(32), .SYNC_STAGES(3), .DEBOUNCE_CYCLES(0), .EDGE_TYPE(2)) u2 (
        .clk(clk), .reset_n(reset_n), .address(address), .chipselect(chipselect),
        .write_n(write_n), .writedata(writedata), .in_port(in2),
        .readdata(rd2), .irq(irq2));

    int cfg_w [3] = '{4, 4, 32};
    int cfg_s [3] = '{2, 2, 3};
    int cfg_n [3] = '{0, 4, 0};
    int cfg_e [3] = '{0, 0, 2};

    logic [31:0] m_s    [3];
    logic [31:0] m_f    [3];
    logic [31:0] m_fd   [3];
    logic [31:0] m_cap  [3];
    logic [31:0] m_mask [3];
    logic [31:0] m_rd   [3];
    logic        m_irq  [3];
    logic [31:0] m_hist [3][8];
    int          m_run  [3][32];
    int          m_k;

    function automatic logic [31:0] in_of(input int i);
        case (i)
            0:       return {28'd0, in0};
            1:       return {28'd0, in1};
            default: return in2;
        endcase
    endfunction

    function automatic logic [31:0] dut_rd(input int i);
        case (i)
            0:       return rd0;
            1:       return rd1;
            default: return rd2;
        endcase
    endfunction

    function automatic logic dut_irq(input int i);
        case (i)
            0:       return irq0;
            1:       return irq1;
            default: return irq2;
        endcase
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_k = 0;
        for (int i = 0; i < 3; i++) begin
            m_s[i] = '0; m_f[i] = '0; m_fd[i] = '0; m_cap[i] = '0;
            m_mask[i] = '0; m_rd[i] = '0; m_irq[i] = 1'b0;
            for (int j = 0; j < 8; j++) m_hist[i][j] = '0;
            for (int b = 0; b < 32; b++) m_run[i][b] = 0;
        end
    endtask

    // One clock of the register-level behaviour, computed from pre-edge values.
    task automatic model_step();
        logic [31:0] wm, ev, clr, nf, ns;
        int src;
        m_k++;
        for (int i = 0; i < 3; i++) begin
            wm = (cfg_w[i] == 32) ? 32'hFFFF_FFFF : ((32'd1 << cfg_w[i]) - 32'd1);
            case (address)
                2'd0:    m_rd[i] = m_f[i];
                2'd1:    m_rd[i] = m_mask[i];
                2'd2:    m_rd[i] = m_cap[i];
                default: m_rd[i] = '0;
            endcase
            m_irq[i] = |(m_cap[i] & m_mask[i]);
            case (cfg_e[i])
                0:       ev = m_f[i] & ~m_fd[i];
                1:       ev = ~m_f[i] & m_fd[i];
                default: ev = m_f[i] ^ m_fd[i];
            endcase
            ev  = ev & wm;
            clr = (chipselect && !write_n && address == 2'd2) ? (writedata & wm) : '0;
            if (chipselect && !write_n && address == 2'd1) m_mask[i] = writedata & wm;
            m_cap[i] = ev | (m_cap[i] & ~clr);
            m_fd[i]  = m_f[i];
            nf = m_f[i];
            if (cfg_n[i] > 0) begin
                for (int b = 0; b < cfg_w[i]; b++) begin
                    if (m_s[i][b] != m_f[i][b]) begin
                        m_run[i][b]++;
                        if (m_run[i][b] == cfg_n[i]) begin
                            nf[b] = m_s[i][b];
                            m_run[i][b] = 0;
                        end
                    end else begin
                        m_run[i][b] = 0;
                    end
                end
            end
            m_hist[i][m_k % 8] = in_of(i) & wm;
            src = m_k - cfg_s[i] + 1;
            ns  = (src >= 1) ? m_hist[i][src % 8] : '0;
            m_s[i] = ns;
            m_f[i] = (cfg_n[i] == 0) ? ns : nf;
        end
    endtask

    initial begin
        model_reset();
        forever begin
            @(posedge clk or negedge reset_n);
            if (!reset_n) model_reset();
            else model_step();
        end
    end

    initial begin
        forever begin
            @(negedge clk);
            for (int i = 0; i < 3; i++) begin
                check($sformatf("model_rd_u%0d", i), dut_rd(i), m_rd[i]);
                check($sformatf("model_irq_u%0d", i), {31'd0, dut_irq(i)}, {31'd0, m_irq[i]});
            end
        end
    end

    task automatic wr(input logic [1:0] a, input logic [31:0] d);
        @(negedge clk);
        chipselect = 1'b1; write_n = 1'b0; address = a; writedata = d;
        @(negedge clk);
        chipselect = 1'b0; write_n = 1'b1; writedata = '0;
    endtask

    task automatic rd_chk(input int i, input logic [1:0] a, input logic [31:0] exp,
                          input string name);
        @(negedge clk);
        address = a;
        @(posedge clk);
        #1;
        check(name, dut_rd(i), exp);
    endtask

    initial begin
        // 1: input held high through reset gives one rising capture
        in0 = 4'hA;
        repeat (3) @(negedge clk);
        address = 2'd2;
        reset_n = 1'b1;
        repeat (3) @(posedge clk);
        #1 check("cap_latency_before", rd0, 32'h0);
        @(posedge clk);
        #1 check("cap_latency_at", rd0, 32'hA);
        check("irq_masked", {31'd0, irq0}, 32'd0);
        rd_chk(0, 2'd0, 32'h0000_000A, "data_read");

        // 2: mask, irq, write-1-to-clear
        wr(2'd1, 32'h2);
        check("irq_not_yet", {31'd0, irq0}, 32'd0);
        @(posedge clk);
        #1 check("irq_after_mask", {31'd0, irq0}, 32'd1);
        wr(2'd2, 32'h2);
        @(posedge clk);
        #1 check("irq_after_clear", {31'd0, irq0}, 32'd0);
        rd_chk(0, 2'd2, 32'h8, "cap_after_clr2");
        wr(2'd2, 32'h8);
        rd_chk(0, 2'd2, 32'h0, "cap_after_clr8");

        // 3: debounce, short glitch then stable step
        @(negedge clk) in1 = 4'h1;
        repeat (3) @(negedge clk);
        in1 = 4'h0;
        repeat (8) @(negedge clk);
        rd_chk(1, 2'd0, 32'h0, "glitch_data");
        rd_chk(1, 2'd2, 32'h0, "glitch_cap");
        @(negedge clk) address = 2'd0;
        @(negedge clk) in1 = 4'h1;
        repeat (6) @(posedge clk);
        #1 check("deb_f_before", rd1, 32'h0);
        @(posedge clk);
        #1 check("deb_f_at", rd1, 32'h1);
        rd_chk(1, 2'd2, 32'h1, "deb_cap");

        // 4: any-edge on bit 31, unused address
        @(negedge clk) in2 = 32'h8000_0000;
        repeat (10) @(negedge clk);
        rd_chk(2, 2'd2, 32'h8000_0000, "any_rise");
        wr(2'd2, 32'h8000_0000);
        rd_chk(2, 2'd2, 32'h0, "any_clr");
        @(negedge clk) in2 = 32'h0;
        repeat (10) @(negedge clk);
        rd_chk(2, 2'd2, 32'h8000_0000, "any_fall");
        wr(2'd3, 32'hFFFF_FFFF);
        rd_chk(2, 2'd1, 32'h2, "addr3_mask_u2");
        rd_chk(0, 2'd1, 32'h2, "addr3_mask_u0");
        rd_chk(2, 2'd2, 32'h8000_0000, "addr3_cap");
        rd_chk(2, 2'd3, 32'h0, "addr3_read");

        // 5: edge coinciding with clear of the same bit
        @(negedge clk) in0 = 4'h8;
        repeat (5) @(negedge clk);
        in0 = 4'hA;
        repeat (5) @(negedge clk);
        check("set_irq", {31'd0, irq0}, 32'd1);
        in0 = 4'h8;
        repeat (5) @(negedge clk);
        in0 = 4'hA;
        @(negedge clk);
        @(negedge clk);
        chipselect = 1'b1; write_n = 1'b0; address = 2'd2; writedata = 32'h2;
        @(negedge clk);
        chipselect = 1'b0; write_n = 1'b1; writedata = '0;
        check("setwin_irq0", {31'd0, irq0}, 32'd1);
        @(posedge clk);
        #1 check("setwin_irq1", {31'd0, irq0}, 32'd1);
        rd_chk(0, 2'd2, 32'h2, "setwin_cap");

        // 6: asynchronous reset mid-debounce
        @(negedge clk) in1 = 4'hF;
        repeat (12) @(negedge clk);
        wr(2'd1, 32'hF);
        @(negedge clk) address = 2'd2;
        repeat (2) @(negedge clk);
        check("pre_rst_cap", rd1, 32'hF);
        check("pre_rst_irq", {31'd0, irq1}, 32'd1);
        in1 = 4'h0;
        repeat (3) @(posedge clk);
        #3 reset_n = 1'b0;
        #1;
        check("rst_rd", rd1, 32'h0);
        check("rst_irq", {31'd0, irq1}, 32'd0);
        check("rst_irq_u0", {31'd0, irq0}, 32'd0);
        @(negedge clk);
        @(negedge clk) reset_n = 1'b1;
        rd_chk(1, 2'd2, 32'h0, "rst_cap");
        rd_chk(1, 2'd1, 32'h0, "rst_mask");
        rd_chk(1, 2'd0, 32'h0, "rst_data");

        repeat (4) @(negedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
